uart_tx_stream: RTL and testbench
=================================

// Module: uart_tx_stream
// PURPOSE
//  Synthesizable 8-bit UART transmitter with input byte FIFO. It accepts bytes on a
//  valid/ready stream and serializes them as 8N1/8E1/8O1 or 2-stop frames, LSB first.
//  It is Patmos's serial output path toward mprj_io, and the bench-side stimulus
//  driver for Patmos's UART receive path.
// PARAMETERS
//  CPB        434  clock cycles per bit, >=2 (50 MHz / 115200 baud)
//  DEPTH      8    FIFO entries, power of two, >=2
//  PARITY     0    0 = none, 1 = even, 2 = odd
//  STOP_BITS  1    1 or 2
// PORTS
//  clk         in   1   single clock
//  rst         in   1   synchronous, active-high reset
//  in_data     in   8   byte to send
//  in_valid    in   1   in_data valid
//  in_ready    out  1   FIFO can accept; = (fifo_count < DEPTH)
//  tx_en       in   1   1 = frames may start; 0 = pause between frames
//  tx          out  1   serial line, idle high (registered)
//  busy        out  1   FSM not in IDLE
//  frame_done  out  1   one-cycle pulse per completed frame
//  fifo_count  out  $clog2(DEPTH)+1  bytes queued (not yet popped)
// BEHAVIOUR
//  - Reset: tx=1, busy=0, frame_done=0, fifo_count=0, in_ready=1; FIFO emptied; FSM=IDLE.
//    Reset mid-frame aborts the frame: tx=1 after the reset edge and no frame_done.
//  - Push on in_valid&&in_ready at an edge. When full, in_ready=0 even if a pop occurs
//    in the same cycle (no pass-through). A push and pop in the same cycle leave
//    fifo_count unchanged. Pointers wrap modulo DEPTH.
//  - FSM states: IDLE, START, DATA, PARITY, STOP. One bit counter (0..CPB-1); every bit
//    period lasts exactly CPB cycles.
//  - IDLE: tx=1. If tx_en && fifo_count!=0, pop head into shift reg -> START.
//    Latency: a byte pushed into an empty FIFO at edge N drives tx=0 from edge N+1.
//  - START: tx=0 for CPB cycles -> DATA.
//  - DATA: 8 bits, LSB first, CPB cycles each -> PARITY if PARITY!=0, else STOP.
//  - PARITY: even sets bit = ^data; odd sets bit = ~^data. CPB cycles -> STOP.
//  - STOP: tx=1 for STOP_BITS*CPB cycles. On the final edge, frame_done=1 for one cycle.
//    If tx_en && fifo_count!=0, pop -> START with no idle gap; else -> IDLE.
//  - tx_en deasserted mid-frame: the current frame completes and no new frame starts.
//  - Frame length is (1+8+(PARITY!=0)+STOP_BITS)*CPB cycles. busy=1 from START
//    through the last STOP cycle.
//  - in_data is ignored while in_valid=0. Behaviour is undefined if parameters are
//    outside the listed ranges.
// TESTING (CPB=4 unless noted)
//  1. Push 0x68 into an idle block, PARITY=0 -> tx sequence 0|0,0,0,1,0,1,1,0|1, each bit
//     4 cycles; tx low 1 cycle after the push; frame_done at cycle 40; busy 40 cycles.
//  2. Burst 0x68,0x69,0x21 -> three contiguous frames (120 cycles, no idle gap); the
//     bench receiver decodes 24'h686921; three frame_done pulses.
//  3. tx_en=0, push 8 bytes -> fifo_count=8, in_ready=0, 9th byte held on in_valid;
//     tx_en=1 -> 9 frames in push order, 9th accepted on the first pop.
//  4. PARITY=1, byte 0x07 -> parity bit 1; PARITY=2 -> 0; frame length 44 cycles.
//  5. STOP_BITS=2, byte 0xFF -> 11*CPB-cycle frame; tx high for the last 8 cycles.
//  6. rst during DATA bit 3 with 2 bytes queued -> tx=1, busy=0, fifo_count=0 next
//     cycle; no frame_done; later push sends a clean frame.

Source files
------------

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: 8-bit UART transmitter fed by a byte FIFO over a valid/ready stream.
// Frames are start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
// Every bit period lasts exactly CPB clock cycles.
//
// Ports:
//   clk_i          single clock
//   rst_i          synchronous, active-high reset; aborts any frame in flight
//   in_data_i      byte to queue
//   in_valid_i     in_data_i valid
//   in_ready_o     FIFO has room (fifo_count_o < DEPTH)
//   tx_en_i        1 = frames may start, 0 = hold off between frames
//   tx_o           serial line, idle high, registered
//   busy_o         a frame is in progress
//   frame_done_o   one-cycle pulse in the last stop-bit cycle of each frame
//   fifo_count_o   bytes queued and not yet popped
module uart_tx_stream #(
   parameter int unsigned CPB       = 434,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [7:0]               in_data_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic                     tx_en_i,
   output logic                     tx_o,
   output logic                     busy_o,
   output logic                     frame_done_o,
   output logic [$clog2(DEPTH):0]   fifo_count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = (CPB > 1) ? $clog2(CPB) : 1;
   localparam logic [AW:0]   FullCount = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0] LastCnt   = CW'(CPB - 1);
   localparam logic [2:0]    LastStop  = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   // FIFO storage and bookkeeping
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic          push, pop;
   logic [7:0]    head;

   // Serializer state
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;     // data bit index, reused as stop-bit index
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic          tx_q, tx_d;
   logic          start_ok;
   logic          bit_end;
   logic          frame_end;

   // Full blocks pushes even when a pop happens in the same cycle.
   assign in_ready_o = (count_q < FullCount);
   assign push       = in_valid_i && in_ready_o;
   assign head       = mem_q[rd_ptr_q];
   assign start_ok   = tx_en_i && (count_q != '0);
   assign bit_end    = (cnt_q == LastCnt);

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + (AW + 1)'(1);
      end else if (!push && pop) begin
         count_d = count_q - (AW + 1)'(1);
      end
   end

   // tx_d describes the line level for the cycle after the edge, so tx_o is registered
   // yet changes on the same edge as the state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_d     = par_q;
      tx_d      = tx_q;
      pop       = 1'b0;
      frame_end = 1'b0;

      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (start_ok) begin
               pop     = 1'b1;
               state_d = StStart;
               tx_d    = 1'b0;
               cnt_d   = '0;
            end
         end
         StStart: begin
            cnt_d = cnt_q + CW'(1);
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = StData;
               tx_d    = shift_q[0];
            end
         end
         StData: begin
            cnt_d = cnt_q + CW'(1);
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  bit_d = '0;
                  if (PARITY != 0) begin
                     state_d = StParity;
                     tx_d    = par_q;
                  end else begin
                     state_d = StStop;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end
         end
         StParity: begin
            cnt_d = cnt_q + CW'(1);
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = StStop;
               tx_d    = 1'b1;
            end
         end
         StStop: begin
            cnt_d = cnt_q + CW'(1);
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == LastStop) begin
                  frame_end = 1'b1;
                  bit_d     = '0;
                  // Back-to-back frames: go straight to the next start bit.
                  if (start_ok) begin
                     pop     = 1'b1;
                     state_d = StStart;
                     tx_d    = 1'b0;
                  end else begin
                     state_d = StIdle;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
         end
      endcase

      if (pop) begin
         shift_d = head;
         par_d   = (PARITY == 2) ? ~^head : ^head;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         tx_q     <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         count_q <= count_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data_i;
      end
   end

   assign tx_o         = tx_q;
   assign busy_o       = (state_q != StIdle);
   assign frame_done_o = frame_end && !rst_i;
   assign fifo_count_o = count_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
module tb_uart_tx_stream;

   localparam int CPB_T = 4;
   localparam int FRAME = 10 * CPB_T;

   logic       clk;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       tx_en;
   logic       tx;
   logic       busy;
   logic       frame_done;
   logic [3:0] fifo_count;

   // Side instances for parity and two-stop-bit frames (index 0: even, 1: odd, 2: 2 stop).
   logic [2:0] xv;
   logic [7:0] xd;
   logic [2:0] tx_x, busy_x, fd_x, rdy_x;
   logic [3:0] cnt_x [3];

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]  exp_q [$];
   int          m_starts [$];
   int          ncyc = 0;
   int          fd_cnt = 0;
   int          m_frames = 0;
   logic        m_active = 1'b0;
   int          m_idx;
   logic [7:0]  m_byte;
   logic        m_bad;
   logic [23:0] m_word = '0;

   uart_tx_stream #(.CPB(CPB_T), .DEPTH(8), .PARITY(0), .STOP_BITS(1)) dut (
      .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_valid_i(in_valid),
      .in_ready_o(in_ready), .tx_en_i(tx_en), .tx_o(tx), .busy_o(busy),
      .frame_done_o(frame_done), .fifo_count_o(fifo_count)
   );

   uart_tx_stream #(.CPB(CPB_T), .DEPTH(8), .PARITY(1), .STOP_BITS(1)) dut_even (
      .clk_i(clk), .rst_i(rst), .in_data_i(xd), .in_valid_i(xv[0]),
      .in_ready_o(rdy_x[0]), .tx_en_i(1'b1), .tx_o(tx_x[0]), .busy_o(busy_x[0]),
      .frame_done_o(fd_x[0]), .fifo_count_o(cnt_x[0])
   );

   uart_tx_stream #(.CPB(CPB_T), .DEPTH(8), .PARITY(2), .STOP_BITS(1)) dut_odd (
      .clk_i(clk), .rst_i(rst), .in_data_i(xd), .in_valid_i(xv[1]),
      .in_ready_o(rdy_x[1]), .tx_en_i(1'b1), .tx_o(tx_x[1]), .busy_o(busy_x[1]),
      .frame_done_o(fd_x[1]), .fifo_count_o(cnt_x[1])
   );

   uart_tx_stream #(.CPB(CPB_T), .DEPTH(8), .PARITY(0), .STOP_BITS(2)) dut_stop2 (
      .clk_i(clk), .rst_i(rst), .in_data_i(xd), .in_valid_i(xv[2]),
      .in_ready_o(rdy_x[2]), .tx_en_i(1'b1), .tx_o(tx_x[2]), .busy_o(busy_x[2]),
      .frame_done_o(fd_x[2]), .fifo_count_o(cnt_x[2])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Offer a byte until accepted; the expected byte enters the scoreboard at the accept edge.
   task automatic push(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      for (int t = 0; t < 2000; t++) begin
         if (in_ready === 1'b1) begin
            @(posedge clk);
            exp_q.push_back(b);
            @(negedge clk);
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("push_timeout", 32'(1), 32'(0));
   endtask

   task automatic wait_idle(input string nm);
      int t;
      t = 0;
      while ((busy !== 1'b0 || exp_q.size() != 0 || fifo_count !== 4'd0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check({nm, "_idle_timeout"}, 32'(t < 3000), 32'(1));
      repeat (2) @(negedge clk);
   endtask

   // Directed frame capture on a side instance: one push, then 48 cycles of line samples.
   task automatic run_x(input int k, input logic [7:0] b, input logic [10:0] slots,
                        input string nm);
      logic [10:0] got;
      logic        stable;
      int          busy_n;
      int          fd_at;
      check({nm, "_ready"}, 32'(rdy_x[k]), 32'(1));
      xd    = b;
      xv[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      xv[k] = 1'b0;
      check({nm, "_tx_at_push"}, 32'(tx_x[k]), 32'(1));
      check({nm, "_count_at_push"}, 32'(cnt_x[k]), 32'(1));
      @(negedge clk);
      got    = '0;
      stable = 1'b1;
      busy_n = 0;
      fd_at  = -1;
      for (int c = 0; c < 48; c++) begin
         if (c < 44) begin
            if (c % CPB_T == 0) got[c / CPB_T] = tx_x[k];
            else if (tx_x[k] !== got[c / CPB_T]) stable = 1'b0;
         end
         if (busy_x[k] === 1'b1) busy_n++;
         if (fd_x[k] === 1'b1) fd_at = c;
         @(negedge clk);
      end
      check({nm, "_slots"}, 32'(got), 32'(slots));
      check({nm, "_bit_period"}, 32'(stable), 32'(1));
      check({nm, "_busy_cycles"}, 32'(busy_n), 32'(44));
      check({nm, "_frame_done_cycle"}, 32'(fd_at), 32'(43));
   endtask

   // Receiver/monitor for the main instance: decodes 8N1 frames sample by sample and pops
   // the scoreboard when a frame closes.
   always @(negedge clk) begin
      int slot;
      int pos;
      ncyc++;
      if (frame_done === 1'b1) fd_cnt++;
      if (rst === 1'b1) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         if (frame_done === 1'b1) check("stray_frame_done", 32'(1), 32'(0));
         if (tx === 1'b0) begin
            m_active = 1'b1;
            m_idx    = 1;
            m_byte   = '0;
            m_bad    = (busy !== 1'b1) || (frame_done !== 1'b0);
            m_starts.push_back(ncyc);
         end
      end else begin
         slot = m_idx / CPB_T;
         pos  = m_idx % CPB_T;
         if (busy !== 1'b1) m_bad = 1'b1;
         if (frame_done !== (m_idx == FRAME - 1)) m_bad = 1'b1;
         if (slot == 0) begin
            if (tx !== 1'b0) m_bad = 1'b1;
         end else if (slot <= 8) begin
            if (pos == 0) m_byte[slot - 1] = tx;
            else if (tx !== m_byte[slot - 1]) m_bad = 1'b1;
         end else if (tx !== 1'b1) begin
            m_bad = 1'b1;
         end
         if (m_idx == FRAME - 1) begin
            m_active = 1'b0;
            m_frames++;
            m_word = {m_word[15:0], m_byte};
            if (exp_q.size() == 0) check("rx_unexpected_frame", 32'(m_byte), 32'hFFFF);
            else check("rx_byte", 32'(m_byte), 32'(exp_q.pop_front()));
            check("rx_frame_shape", 32'(m_bad), 32'(0));
         end else begin
            m_idx++;
         end
      end
   end

   initial begin
      int fr0;
      int fd0;
      int st0;
      int busy_n;
      rst      = 1'b1;
      tx_en    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      xv       = '0;
      xd       = '0;
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 32'(1));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_frame_done", 32'(frame_done), 32'(0));
      check("rst_count", 32'(fifo_count), 32'(0));
      check("rst_ready", 32'(in_ready), 32'(1));
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1: single byte, latency and frame timing
      fr0 = m_frames;
      fd0 = fd_cnt;
      push(8'h68);
      check("t1_tx_at_push", 32'(tx), 32'(1));
      check("t1_count_at_push", 32'(fifo_count), 32'(1));
      @(negedge clk);
      check("t1_tx_start", 32'(tx), 32'(0));
      check("t1_count_popped", 32'(fifo_count), 32'(0));
      busy_n = 0;
      for (int c = 0; c < 48; c++) begin
         if (busy === 1'b1) busy_n++;
         @(negedge clk);
      end
      check("t1_busy_cycles", 32'(busy_n), 32'(40));
      check("t1_frames", 32'(m_frames - fr0), 32'(1));
      check("t1_frame_done_pulses", 32'(fd_cnt - fd0), 32'(1));

      // 2: burst of three, no idle gap
      fr0 = m_frames;
      fd0 = fd_cnt;
      st0 = m_starts.size();
      push(8'h68);
      push(8'h69);
      push(8'h21);
      wait_idle("t2");
      check("t2_frames", 32'(m_frames - fr0), 32'(3));
      check("t2_word", 32'(m_word), 32'h686921);
      check("t2_frame_done_pulses", 32'(fd_cnt - fd0), 32'(3));
      if (m_starts.size() >= st0 + 3) begin
         check("t2_gap_1", 32'(m_starts[st0 + 1] - m_starts[st0]), 32'(FRAME));
         check("t2_gap_2", 32'(m_starts[st0 + 2] - m_starts[st0 + 1]), 32'(FRAME));
      end else begin
         check("t2_start_count", 32'(m_starts.size() - st0), 32'(3));
      end

      // 3: fill while paused, 9th byte waits for the first pop
      fr0   = m_frames;
      tx_en = 1'b0;
      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
      @(negedge clk);
      check("t3_full_count", 32'(fifo_count), 32'(8));
      check("t3_full_ready", 32'(in_ready), 32'(0));
      check("t3_paused_busy", 32'(busy), 32'(0));
      fork
         push(8'h18);
         begin
            repeat (3) @(negedge clk);
            check("t3_held_ready", 32'(in_ready), 32'(0));
            tx_en = 1'b1;
         end
      join
      check("t3_refill_count", 32'(fifo_count), 32'(8));
      wait_idle("t3");
      check("t3_frames", 32'(m_frames - fr0), 32'(9));

      // 4/5: parity and two stop bits on the side instances
      run_x(0, 8'h07, 11'b110_0000_1110, "t4_even");
      run_x(1, 8'h07, 11'b100_0000_1110, "t4_odd");
      run_x(2, 8'hFF, 11'b111_1111_1110, "t5_stop2");

      // 6: reset during data bit 3 with two bytes still queued
      fr0 = m_frames;
      fd0 = fd_cnt;
      push(8'hA5);
      push(8'h3C);
      push(8'h96);
      check("t6_queued", 32'(fifo_count), 32'(2));
      repeat (15) @(negedge clk);
      check("t6_busy_before", 32'(busy), 32'(1));
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("t6_tx", 32'(tx), 32'(1));
      check("t6_busy", 32'(busy), 32'(0));
      check("t6_count", 32'(fifo_count), 32'(0));
      check("t6_ready", 32'(in_ready), 32'(1));
      @(negedge clk);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      check("t6_no_frame_done", 32'(fd_cnt - fd0), 32'(0));
      check("t6_no_frame", 32'(m_frames - fr0), 32'(0));
      push(8'h5A);
      wait_idle("t6");
      check("t6_clean_frames", 32'(m_frames - fr0), 32'(1));
      check("t6_clean_byte", 32'(m_word[7:0]), 32'h5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
